apb4_master_bridge: RTL

APB4 requester (master) converting a simple valid/ready command stream into APB4 transfers toward `apb4_csr_top`, and returning a response per command. It is the RTL counterpart of the slave side of `Bus2Master_intf`, for use by on-chip sequencers and firmware bridges that program the CSR map. One transfer is in flight at a time. A programmable wait-state timeout protects against a hung slave.

---
 rtl/apb4_master_bridge.sv | 119 +++++++++++
 1 files changed

// File: rtl/apb4_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into one APB4 transfer at a time
// and returns one response per command, with an optional ACCESS-phase wait-state timeout.
module apb4_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // Gated by presetn so no command can be taken while reset is held.
    assign cmd_ready = (state == IDLE) && presetn;
    assign pprot     = PPROT_VAL;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        psel   <= 1'b1;
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        pstrb  <= cmd_write ? cmd_strb : {STRB_WIDTH{1'b0}};
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout expiring in the same cycle.
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        pwrite    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? {DATA_WIDTH{1'b0}} : prdata;
                        state     <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        pwrite      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
